// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: opcodes, special register tags and the
// scoreboard entry used by the interlock and forwarding logic.
package simplerisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  // Tags 0-15 are architectural registers; 16 is the flags pseudo-register.
  localparam logic [4:0] TAG_FLAGS = 5'd16;
  localparam logic [4:0] TAG_RA    = 5'd15;

  localparam logic [31:0] NOP_IR = 32'h68000000;

  typedef struct packed {
    logic       valid;
    logic [4:0] tag;
    logic       is_ld;
  } sb_entry_t;

endpackage

// File: rtl/isa_reg_decode.sv
// Combinational register-usage decoder: which tags an instruction reads and
// writes. Shared by the interlock and forwarding units.
module isa_reg_decode
  import simplerisc_pkg::*;
(
  input  logic [31:0] ir,
  output logic        src1_v,
  output logic [4:0]  src1,
  output logic        src2_v,
  output logic [4:0]  src2,
  output logic        src3_v,
  output logic [4:0]  src3,
  output logic        dst_v,
  output logic [4:0]  dst,
  output logic        is_ld
);

  logic [4:0] opcode;
  logic       imm;
  logic [4:0] rd_tag;
  logic [4:0] rs1_tag;
  logic [4:0] rs2_tag;

  assign opcode  = ir[31:27];
  assign imm     = ir[26];
  assign rd_tag  = {1'b0, ir[25:22]};
  assign rs1_tag = {1'b0, ir[21:18]};
  assign rs2_tag = {1'b0, ir[17:14]};

  always_comb begin
    src1_v = 1'b0;
    src1   = rs1_tag;
    src2_v = 1'b0;
    src2   = rs2_tag;
    src3_v = 1'b0;
    src3   = rd_tag;
    dst_v  = 1'b0;
    dst    = rd_tag;
    is_ld  = 1'b0;
    if (ir != NOP_IR) begin
      case (opcode)
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
        OP_LSL, OP_LSR, OP_ASR: begin
          src1_v = 1'b1;
          src2_v = ~imm;
          dst_v  = 1'b1;
        end
        OP_CMP: begin
          src1_v = 1'b1;
          src2_v = ~imm;
          dst_v  = 1'b1;
          dst    = TAG_FLAGS;
        end
        OP_NOT, OP_MOV: begin
          src2_v = ~imm;
          dst_v  = 1'b1;
        end
        OP_LD: begin
          src1_v = 1'b1;
          dst_v  = 1'b1;
          is_ld  = 1'b1;
        end
        OP_ST: begin
          src1_v = 1'b1;
          src3_v = 1'b1;
        end
        OP_BEQ, OP_BGT: begin
          src1_v = 1'b1;
          src1   = TAG_FLAGS;
        end
        OP_RET: begin
          src1_v = 1'b1;
          src1   = TAG_RA;
        end
        OP_CALL: begin
          dst_v = 1'b1;
          dst   = TAG_RA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/interlock_unit.sv
// Pipeline hazard detection against an EX/MA/RW writer scoreboard, with stall
// statistics. Define FORWARDING_EN to interlock only on load-use hazards.
module interlock_unit
  import simplerisc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      output_OF_IR,
  input  logic             isBranchTaken,
  output logic             isDataInterLock,
  output logic             isBranchInterLock,
  output logic             pc_stall,
  output logic [CNT_W-1:0] data_stall_count,
  output logic [CNT_W-1:0] branch_flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       src1_v, src2_v, src3_v, dst_v, is_ld;
  logic [4:0] src1, src2, src3, dst;

  isa_reg_decode u_decode (
    .ir     (output_OF_IR),
    .src1_v (src1_v),
    .src1   (src1),
    .src2_v (src2_v),
    .src2   (src2),
    .src3_v (src3_v),
    .src3   (src3),
    .dst_v  (dst_v),
    .dst    (dst),
    .is_ld  (is_ld)
  );

  // Index 0 = EX, 1 = MA, 2 = RW.
  sb_entry_t        sb_reg [0:2];
  sb_entry_t        of_entry;
  logic [2:0]       entry_hit;
  logic             hazard;
  logic [CNT_W-1:0] data_stall_count_reg;
  logic [CNT_W-1:0] branch_flush_count_reg;

  assign of_entry = '{valid: dst_v, tag: dst, is_ld: is_ld};

  for (genvar gi = 0; gi < 3; gi++) begin : g_hit
    assign entry_hit[gi] = sb_reg[gi].valid &&
                           ((src1_v && (src1 == sb_reg[gi].tag)) ||
                            (src2_v && (src2 == sb_reg[gi].tag)) ||
                            (src3_v && (src3 == sb_reg[gi].tag)));
  end

`ifdef FORWARDING_EN
  // Bypass covers everything except a load whose data is not ready yet.
  assign hazard = entry_hit[0] && sb_reg[0].is_ld;
`else
  assign hazard = |entry_hit;
`endif

  assign isBranchInterLock = isBranchTaken;
  assign isDataInterLock   = hazard && !isBranchTaken;
  assign pc_stall          = isDataInterLock && !isBranchInterLock;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) sb_reg[k] <= '0;
      data_stall_count_reg   <= '0;
      branch_flush_count_reg <= '0;
    end else begin
      sb_reg[2] <= sb_reg[1];
      sb_reg[1] <= sb_reg[0];
      sb_reg[0] <= (isDataInterLock || isBranchInterLock) ? '0 : of_entry;
      if (pc_stall && (data_stall_count_reg != CNT_MAX))
        data_stall_count_reg <= data_stall_count_reg + 1'b1;
      if (isBranchInterLock && (branch_flush_count_reg != CNT_MAX))
        branch_flush_count_reg <= branch_flush_count_reg + 1'b1;
    end
  end

  assign data_stall_count   = data_stall_count_reg;
  assign branch_flush_count = branch_flush_count_reg;

endmodule

// File: doc/interlock_unit.md
Name: interlock_unit

Overview:
- Hazard-detection block for the 5-stage pipeline. It generates isDataInterLock and isBranchInterLock, which the OF/EX latch consumes.
- It decodes the instruction currently in OF and compares its source tags against a 3-deep scoreboard of in-flight writers in EX, MA and RW.
- It also stalls the PC and the IF/OF latch, and keeps stall statistics.

Parameters:
- NOP_IR, 32'h68000000, encoding treated as a bubble that writes nothing.
- CNT_W, 16, width of the saturating stall/flush counters.

Ports:
- clk  input  1  pipeline clock; all state updates on negedge clk.
- reset_n  input  1  asynchronous, active-low reset.
- output_OF_IR  input  32  instruction currently in OF.
- isBranchTaken  input  1  EX-stage branch resolved taken (combinational from EX).
- isDataInterLock  output  1  insert bubble into EX and hold PC and IF/OF.
- isBranchInterLock  output  1  flush IF/OF and OF/EX.
- pc_stall  output  1  hold PC and IF/OF latch (= isDataInterLock & ~isBranchInterLock).
- data_stall_count  output  CNT_W  cycles with pc_stall high, saturating.
- branch_flush_count  output  CNT_W  cycles with isBranchInterLock high, saturating.

Behaviour:
Decode fields (SimpleRISC): opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14].
- Tags are 5 bits: 0-15 are registers, 16 is the flags pseudo-register.

Sources by opcode:
- add, sub, mul, div, mod, cmp, and, or, lsl, lsr, asr (00000-00111, 01010-01100): rs1, plus rs2 when I=0.
- not, mov (01000, 01001): rs2 when I=0.
- ld (01110): rs1.
- st (01111): rs1 and rd.
- beq, bgt (10000, 10001): flags.
- ret (10100): r15.
- nop, b, call: none.

Writers:
- ALU ops except cmp, plus mov and ld: rd.
- cmp: flags.
- call: r15.
- Everything else: none.

Scoreboard:
- Three entries, SB_EX, SB_MA, SB_RW, each {valid, tag[4:0], is_ld}.
- On every negedge: SB_RW <= SB_MA, SB_MA <= SB_EX.
- SB_EX <= invalid if isDataInterLock | isBranchInterLock; otherwise SB_EX <= decode(output_OF_IR).

Hazard logic (combinational from output_OF_IR and the scoreboard):
- hazard = any valid OF source tag equals the tag of a valid entry in SB_EX, SB_MA or SB_RW.
- isBranchInterLock = isBranchTaken.
- isDataInterLock = hazard & ~isBranchTaken. Branch has priority: a wrong-path OF instruction never stalls.

Boundary conditions:
- I=1: rs2 is not compared.
- Two sources matching the same entry produce a single stall; no double counting.
- A stall persists while a matching entry remains. Without forwarding, the maximum is 3 consecutive cycles for one producer.
- Counters increment by 1 per qualifying cycle and hold at 2^CNT_W-1.

Reset (reset_n low, asynchronous, mid-operation included):
- All scoreboard entries invalid.
- Counters cleared to 0.
- Outputs therefore 0 until the first OF instruction with a hazard.

Optional Feature:
- FORWARDING_EN defined: hazard = a valid source matches SB_EX only when SB_EX.is_ld=1 (load-use). This gives at most one stall cycle. MA and RW matches are ignored because the bypass network covers them.
- Undefined: full no-bypass interlock as described above.

Decomposition:
- Package simplerisc_pkg holds:
  - opcode localparams (OP_ADD … OP_RET, OP_NOP = 5'b01101);
  - TAG_FLAGS = 5'd16, TAG_RA = 5'd15;
  - NOP_IR;
  - scoreboard entry typedef.
- Sub-module isa_reg_decode (combinational): IR -> {src1_v, src1, src2_v, src2, src3_v, src3, dst_v, dst, is_ld}. It is reusable by the forwarding unit.

Test Plan:
- Reset: reset_n=0 mid-stream with the scoreboard full -> all outputs 0 immediately, counters 0, and no stall on the next dependent instruction.
- RAW, no forwarding: OF=0x0048C000 (add r1,r2,r3), then OF=0x09054000 (sub r4,r1,r5) held -> isDataInterLock=1 and pc_stall=1 for exactly 3 cycles, then 0; data_stall_count=3.
- Flags: cmp r2,r3 then beq -> stall 3 cycles without FORWARDING_EN, 0 cycles with it.
- Load-use with FORWARDING_EN: ld r1,[r2] then add r4,r1,r5 -> exactly 1 stall cycle. A non-load producer gives 0 stall cycles.
- Branch priority: isBranchTaken=1 while the OF instruction depends on SB_EX -> isBranchInterLock=1, isDataInterLock=0, pc_stall=0, SB_EX bubble inserted, branch_flush_count increments.
- Saturation and immediates: force CNT_W=2 and stall 5 cycles -> data_stall_count=3. add r1,r2,#imm (I=1) with rs2 field equal to an in-flight rd -> no stall.
